// File: rtl/iiitb_sd_seq_gen.sv
// Serial sequence transmitter: shifts a parallel frame out MSB-first and counts
// occurrences of PATTERN on the line it drives.
module iiitb_sd_seq_gen #(
  parameter int                 WIDTH      = 8,
  parameter int                 GAP_CYCLES = 1,
  parameter logic               IDLE_LEVEL = 1'b0,
  parameter int                 PAT_LEN    = 4,
  parameter logic [PAT_LEN-1:0] PATTERN    = 4'b1011
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH):0]   len,
  input  logic                     valid,
  output logic                     ready,
  output logic                     sequence_out,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              match_count
);

  localparam int LW       = $clog2(WIDTH) + 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int FW       = $clog2(PAT_LEN) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    shift_reg;
  logic [LW-1:0]       bits_left_reg;
  logic [GW-1:0]       gap_reg;
  logic [PAT_LEN-1:0]  hist_reg;
  logic [FW-1:0]       fill_reg;

  logic [LW-1:0]       n_sel;
  logic [WIDTH-1:0]    aligned;
  logic [PAT_LEN-1:0]  hist_next;

  // Left-align the active field so the first bit to send sits in the MSB.
  always_comb begin
    n_sel     = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;
    aligned   = data_in << (LW'(WIDTH) - n_sel);
    hist_next = {hist_reg[PAT_LEN-2:0], sequence_out};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bits_left_reg <= '0;
      gap_reg       <= '0;
      hist_reg      <= '0;
      fill_reg      <= '0;
      sequence_out  <= IDLE_LEVEL;
      ready         <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      match_count   <= '0;
    end else begin
      // The line is sampled every cycle, idle bits included.
      hist_reg <= hist_next;
      if (fill_reg != FW'(PAT_LEN))
        fill_reg <= fill_reg + 1'b1;
      if (hist_next == PATTERN && fill_reg >= FW'(PAT_LEN - 1) && match_count != 16'hFFFF)
        match_count <= match_count + 16'd1;

      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid) begin
            state_reg     <= SHIFT;
            sequence_out  <= aligned[WIDTH-1];
            shift_reg     <= aligned << 1;
            bits_left_reg <= n_sel - 1'b1;
            ready         <= 1'b0;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          if (bits_left_reg != '0) begin
            sequence_out  <= shift_reg[WIDTH-1];
            shift_reg     <= shift_reg << 1;
            bits_left_reg <= bits_left_reg - 1'b1;
          end else begin
            sequence_out <= IDLE_LEVEL;
            if (GAP_CYCLES == 0) begin
              state_reg <= IDLE;
              ready     <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= GAP;
              gap_reg   <= GW'(GAP_LOAD);
            end
          end
        end
        GAP: begin
          if (gap_reg == '0) begin
            state_reg <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            gap_reg <= gap_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
